// File: rtl/dht11_report_sched_if.sv
// Byte-stream handshake between the report scheduler and the UART transmitter.
// The master holds tx_data/tx_valid until the slave accepts with tx_ready.
interface dht11_report_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dht11_report_sched.sv
// Periodic DHT11 measurement scheduler: requests a read, waits for the frame,
// snapshots the ASCII digits and streams a fixed-format text report to the UART.
module dht11_report_sched #(
  parameter int PERIOD_CYC  = 100_000_000,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        enable,
  output logic                        meas_req,
  input  logic                        meas_done,
  input  logic                        meas_ok,
  input  logic                        sign,
  input  logic [23:0]                 t_ascii,
  input  logic [23:0]                 h_ascii,
  dht11_report_sched_if.master        tx,
  output logic                        report_busy,
  output logic [7:0]                  err_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SETTLE, SEND, GAP} state_t;

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [4:0]    NORMAL_LAST  = 5'd17;
  localparam logic [4:0]    ERROR_LAST   = 5'd4;

  state_t        state_reg, state_next;
  logic [PW-1:0] period_reg, period_next;
  logic [TW-1:0] timeout_reg, timeout_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [4:0]    idx_reg, idx_next;
  logic [7:0]    err_reg, err_next;
  logic          err_msg_reg, err_msg_next;
  logic          sign_reg, sign_next;
  logic [23:0]   t_reg, t_next;
  logic [23:0]   h_reg, h_next;
  logic [7:0]    byte_sel;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      period_reg  <= '0;
      timeout_reg <= '0;
      settle_reg  <= '0;
      idx_reg     <= '0;
      err_reg     <= '0;
      err_msg_reg <= 1'b0;
      sign_reg    <= 1'b0;
      t_reg       <= '0;
      h_reg       <= '0;
    end else begin
      state_reg   <= state_next;
      period_reg  <= period_next;
      timeout_reg <= timeout_next;
      settle_reg  <= settle_next;
      idx_reg     <= idx_next;
      err_reg     <= err_next;
      err_msg_reg <= err_msg_next;
      sign_reg    <= sign_next;
      t_reg       <= t_next;
      h_reg       <= h_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    period_next  = (period_reg == PERIOD_LAST) ? period_reg : period_reg + 1'b1;
    timeout_next = timeout_reg;
    settle_next  = settle_reg;
    idx_next     = idx_reg;
    err_next     = err_reg;
    err_msg_next = err_msg_reg;
    sign_next    = sign_reg;
    t_next       = t_reg;
    h_next       = h_reg;

    case (state_reg)
      IDLE: begin
        if (enable) state_next = REQ;
      end
      REQ: begin
        // The REQ cycle itself is cycle 0 of the period, so the next value is 1.
        period_next  = PW'(1);
        timeout_next = '0;
        state_next   = WAIT;
      end
      WAIT: begin
        timeout_next = timeout_reg + 1'b1;
        if (meas_done && meas_ok) begin
          settle_next = '0;
          state_next  = SETTLE;
        end else if ((meas_done && !meas_ok) || (timeout_reg == TIMEOUT_LAST)) begin
          err_msg_next = 1'b1;
          idx_next     = '0;
          err_next     = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
          state_next   = SEND;
        end else if (!enable) begin
          state_next = IDLE;
        end
      end
      SETTLE: begin
        settle_next = settle_reg + 1'b1;
        if (settle_reg == SETTLE_LAST) begin
          sign_next    = sign;
          t_next       = t_ascii;
          h_next       = h_ascii;
          err_msg_next = 1'b0;
          idx_next     = '0;
          state_next   = SEND;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (idx_reg == (err_msg_reg ? ERROR_LAST : NORMAL_LAST)) state_next = GAP;
          else idx_next = idx_reg + 5'd1;
        end
      end
      GAP: begin
        // A saturated period counter makes an overdue request fire on the first GAP cycle.
        if (!enable) state_next = IDLE;
        else if (period_reg == PERIOD_LAST) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    if (err_msg_reg) begin
      case (idx_reg)
        5'd0:       byte_sel = "E";
        5'd1, 5'd2: byte_sel = "R";
        5'd3:       byte_sel = 8'h0D;
        5'd4:       byte_sel = 8'h0A;
        default:    byte_sel = 8'h00;
      endcase
    end else begin
      case (idx_reg)
        5'd0:    byte_sel = "T";
        5'd1:    byte_sel = ":";
        5'd2:    byte_sel = sign_reg ? "-" : "+";
        5'd3:    byte_sel = t_reg[23:16];
        5'd4:    byte_sel = t_reg[15:8];
        5'd5:    byte_sel = ".";
        5'd6:    byte_sel = t_reg[7:0];
        5'd7:    byte_sel = "C";
        5'd8:    byte_sel = " ";
        5'd9:    byte_sel = "H";
        5'd10:   byte_sel = ":";
        5'd11:   byte_sel = h_reg[23:16];
        5'd12:   byte_sel = h_reg[15:8];
        5'd13:   byte_sel = ".";
        5'd14:   byte_sel = h_reg[7:0];
        5'd15:   byte_sel = "%";
        5'd16:   byte_sel = 8'h0D;
        5'd17:   byte_sel = 8'h0A;
        default: byte_sel = 8'h00;
      endcase
    end
  end

  assign meas_req    = (state_reg == REQ);
  assign tx.tx_valid = (state_reg == SEND);
  assign tx.tx_data  = (state_reg == SEND) ? byte_sel : 8'h00;
  assign report_busy = (state_reg != IDLE) && (state_reg != GAP);
  assign err_cnt     = err_reg;

endmodule
